// File: rtl/aes_xts_out_stage_if.sv
// rtl/aes_xts_out_stage_if.sv - tweak/AES/output handshake bundle for aes_xts_out_stage
// Purpose: groups every non-clock, non-reset signal of the XTS output stage.
// Ports (slave = stage side):
//   inTweakWr/inTweak      tweak push,           outTweakFull  tweak FIFO full
//   inAesWr/inAesData      AES result strobe,    outAesReady   stage can take a block
//   outValid/outData       whitened block,       inReady       downstream accepts
//   inFlush, inErrClr      flush / error clear,  outErr, outBlkCnt
interface aes_xts_out_stage_if #(
  parameter int CNT_W = 16
);
  logic             inTweakWr;
  logic [127:0]     inTweak;
  logic             outTweakFull;
  logic             inAesWr;
  logic [127:0]     inAesData;
  logic             outAesReady;
  logic             outValid;
  logic [127:0]     outData;
  logic             inReady;
  logic             inFlush;
  logic             inErrClr;
  logic [1:0]       outErr;
  logic [CNT_W-1:0] outBlkCnt;

  modport slave (
    input  inTweakWr, inTweak, inAesWr, inAesData, inReady, inFlush, inErrClr,
    output outTweakFull, outAesReady, outValid, outData, outErr, outBlkCnt
  );

  modport master (
    output inTweakWr, inTweak, inAesWr, inAesData, inReady, inFlush, inErrClr,
    input  outTweakFull, outAesReady, outValid, outData, outErr, outBlkCnt
  );
endinterface

// File: rtl/aes_xts_out_stage.sv
// rtl/aes_xts_out_stage.sv - XTS post-whitening (AES result XOR tweak) with output FIFO
// Purpose: pairs each AES result with the oldest buffered tweak, XORs them and
//   queues the whitened block for a valid/ready consumer.
// Ports: inClk, inRst (async, active-high), bus (aes_xts_out_stage_if.slave).
// Optional: AES_XTS_OUT_XOR_PIPE_EN registers the XOR result before the output
//   FIFO push (latency 2 instead of 1).
module aes_xts_out_stage #(
  parameter int TWEAK_DEPTH = 4,
  parameter int OUT_DEPTH   = 2,
  parameter int CNT_W       = 16
) (
  input logic                inClk,
  input logic                inRst,
  aes_xts_out_stage_if.slave bus
);
  localparam int TW_AW  = $clog2(TWEAK_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam logic [TW_AW:0]  TW_FULL  = (TW_AW+1)'(TWEAK_DEPTH);
  localparam logic [OUT_AW:0] OUT_FULL = (OUT_AW+1)'(OUT_DEPTH);

  logic [TWEAK_DEPTH-1:0][127:0] tw_mem_q, tw_mem_d;
  logic [TW_AW-1:0]              tw_wr_q, tw_wr_d, tw_rd_q, tw_rd_d;
  logic [TW_AW:0]                tw_cnt_q, tw_cnt_d;
  logic                          tw_full_q, tw_full_d;
  logic [OUT_DEPTH-1:0][127:0]   out_mem_q, out_mem_d;
  logic [OUT_AW-1:0]             out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OUT_AW:0]               out_cnt_q, out_cnt_d;
  logic                          aes_rdy_q, aes_rdy_d;
  logic [1:0]                    err_q, err_d;
  logic [CNT_W-1:0]              blk_cnt_q, blk_cnt_d;
`ifdef AES_XTS_OUT_XOR_PIPE_EN
  logic                          pipe_vld_q, pipe_vld_d;
  logic [127:0]                  pipe_data_q, pipe_data_d;
  logic [OUT_AW+1:0]             occ_d;
`endif

  logic         flush, tw_push, tw_ovr, aes_acc, aes_ovr, out_valid, out_pop, out_push;
  logic [127:0] xor_data, out_push_data;

  always_comb begin
    flush     = bus.inFlush;
    // Ready/full are registered, so these qualify inputs against last cycle's state.
    tw_push   = bus.inTweakWr & ~tw_full_q & ~flush;
    tw_ovr    = bus.inTweakWr &  tw_full_q & ~flush;
    aes_acc   = bus.inAesWr   &  aes_rdy_q & ~flush;
    aes_ovr   = bus.inAesWr   & ~aes_rdy_q & ~flush;
    xor_data  = bus.inAesData ^ tw_mem_q[tw_rd_q];
    out_valid = (out_cnt_q != '0);
    out_pop   = out_valid & bus.inReady & ~flush;
`ifdef AES_XTS_OUT_XOR_PIPE_EN
    pipe_vld_d    = aes_acc;
    pipe_data_d   = aes_acc ? xor_data : pipe_data_q;
    out_push      = pipe_vld_q & ~flush;
    out_push_data = pipe_data_q;
`else
    out_push      = aes_acc;
    out_push_data = xor_data;
`endif

    tw_mem_d  = tw_mem_q;
    tw_wr_d   = tw_wr_q;
    tw_rd_d   = tw_rd_q;
    tw_cnt_d  = tw_cnt_q;
    out_mem_d = out_mem_q;
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    out_cnt_d = out_cnt_q;
    if (flush) begin
      tw_wr_d   = '0;
      tw_rd_d   = '0;
      tw_cnt_d  = '0;
      out_wr_d  = '0;
      out_rd_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (tw_push) begin
        tw_mem_d[tw_wr_q] = bus.inTweak;
        tw_wr_d = tw_wr_q + TW_AW'(1);
      end
      if (aes_acc) tw_rd_d = tw_rd_q + TW_AW'(1);
      case ({tw_push, aes_acc})
        2'b10:   tw_cnt_d = tw_cnt_q + (TW_AW+1)'(1);
        2'b01:   tw_cnt_d = tw_cnt_q - (TW_AW+1)'(1);
        default: tw_cnt_d = tw_cnt_q;
      endcase
      if (out_push) begin
        out_mem_d[out_wr_q] = out_push_data;
        out_wr_d = out_wr_q + OUT_AW'(1);
      end
      if (out_pop) out_rd_d = out_rd_q + OUT_AW'(1);
      case ({out_push, out_pop})
        2'b10:   out_cnt_d = out_cnt_q + (OUT_AW+1)'(1);
        2'b01:   out_cnt_d = out_cnt_q - (OUT_AW+1)'(1);
        default: out_cnt_d = out_cnt_q;
      endcase
    end

    tw_full_d = (tw_cnt_d == TW_FULL);
`ifdef AES_XTS_OUT_XOR_PIPE_EN
    if (flush) pipe_vld_d = 1'b0;
    // Count the in-flight block so it always finds a free output slot.
    occ_d     = {1'b0, out_cnt_d} + {{(OUT_AW+1){1'b0}}, pipe_vld_d};
    aes_rdy_d = (tw_cnt_d != '0) && (occ_d < {1'b0, OUT_FULL});
`else
    aes_rdy_d = (tw_cnt_d != '0) && (out_cnt_d < OUT_FULL);
`endif

    // Clear first so an error event in the same cycle keeps its bit set.
    err_d    = bus.inErrClr ? 2'b00 : err_q;
    err_d[0] = err_d[0] | aes_ovr;
    err_d[1] = err_d[1] | tw_ovr;

    blk_cnt_d = out_pop ? blk_cnt_q + CNT_W'(1) : blk_cnt_q;
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      tw_mem_q    <= '0;
      tw_wr_q     <= '0;
      tw_rd_q     <= '0;
      tw_cnt_q    <= '0;
      tw_full_q   <= 1'b0;
      out_mem_q   <= '0;
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      out_cnt_q   <= '0;
      aes_rdy_q   <= 1'b0;
      err_q       <= '0;
      blk_cnt_q   <= '0;
`ifdef AES_XTS_OUT_XOR_PIPE_EN
      pipe_vld_q  <= 1'b0;
      pipe_data_q <= '0;
`endif
    end else begin
      tw_mem_q    <= tw_mem_d;
      tw_wr_q     <= tw_wr_d;
      tw_rd_q     <= tw_rd_d;
      tw_cnt_q    <= tw_cnt_d;
      tw_full_q   <= tw_full_d;
      out_mem_q   <= out_mem_d;
      out_wr_q    <= out_wr_d;
      out_rd_q    <= out_rd_d;
      out_cnt_q   <= out_cnt_d;
      aes_rdy_q   <= aes_rdy_d;
      err_q       <= err_d;
      blk_cnt_q   <= blk_cnt_d;
`ifdef AES_XTS_OUT_XOR_PIPE_EN
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
`endif
    end
  end

  assign bus.outTweakFull = tw_full_q;
  assign bus.outAesReady  = aes_rdy_q;
  assign bus.outValid     = out_valid;
  assign bus.outData      = out_mem_q[out_rd_q];
  assign bus.outErr       = err_q;
  assign bus.outBlkCnt    = blk_cnt_q;
endmodule

// File: tb/tb_aes_xts_out_stage.sv
// tb/tb_aes_xts_out_stage.sv - self-checking bench for aes_xts_out_stage
module tb_aes_xts_out_stage;
  localparam int TD = 4;
  localparam int OD = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_xts_out_stage_if #(.CNT_W(CW)) bif ();

  aes_xts_out_stage #(.TWEAK_DEPTH(TD), .OUT_DEPTH(OD), .CNT_W(CW)) dut (
    .inClk(clk),
    .inRst(rst),
    .bus  (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] tq[$];
  logic [127:0] oq[$];
  logic [127:0] pq[$];
  logic [1:0]   m_err = 2'b00;
  int           m_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return (tq.size() > 0) && ((oq.size() + pq.size()) < OD);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    tq.delete(); oq.delete(); pq.delete();
    m_err = 2'b00;
    m_cnt = 0;
  endtask

  // One clock of the behavioural model, using the inputs held during that clock.
  task automatic model_apply();
    bit rdy, full;
    rdy  = m_ready();
    full = (tq.size() == TD);
    if (bif.inErrClr) m_err = 2'b00;
    if (bif.inFlush) begin
      tq.delete(); oq.delete(); pq.delete();
      return;
    end
    if (oq.size() > 0 && bif.inReady) begin
      void'(oq.pop_front());
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    if (pq.size() > 0) oq.push_back(pq.pop_front());
    if (bif.inAesWr) begin
      if (rdy) begin
`ifdef AES_XTS_OUT_XOR_PIPE_EN
        pq.push_back(bif.inAesData ^ tq.pop_front());
`else
        oq.push_back(bif.inAesData ^ tq.pop_front());
`endif
      end else m_err[0] = 1'b1;
    end
    if (bif.inTweakWr) begin
      if (full) m_err[1] = 1'b1;
      else tq.push_back(bif.inTweak);
    end
  endtask

  task automatic verify();
    check("valid", bif.outValid, oq.size() > 0);
    if (oq.size() > 0) check("data", bif.outData, oq[0]);
    check("tweak_full", bif.outTweakFull, tq.size() == TD);
    check("aes_ready", bif.outAesReady, m_ready());
    check("err", bif.outErr, m_err);
    check("blk_cnt", bif.outBlkCnt, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_apply();
    verify();
    bif.inTweakWr = 1'b0;
    bif.inAesWr   = 1'b0;
    bif.inFlush   = 1'b0;
    bif.inErrClr  = 1'b0;
  endtask

  task automatic push_tweak(input logic [127:0] t);
    bif.inTweakWr = 1'b1;
    bif.inTweak   = t;
    step();
  endtask

  // Waits (bounded) for the model to say ready, then issues one AES write.
  task automatic issue_aes(input logic [127:0] d);
    int n;
    n = 0;
    while (!m_ready() && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("aes_wait_timeout", 0, 1);
    bif.inAesWr   = 1'b1;
    bif.inAesData = d;
    step();
  endtask

  task automatic drain();
    int n;
    bif.inReady = 1'b1;
    n = 0;
    while ((oq.size() > 0 || pq.size() > 0) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    verify();
  endtask

  initial begin
    int issued, n, cnt_before;
    bif.inTweakWr = 1'b0; bif.inTweak   = '0;
    bif.inAesWr   = 1'b0; bif.inAesData = '0;
    bif.inReady   = 1'b1; bif.inFlush   = 1'b0;
    bif.inErrClr  = 1'b0;

    do_reset();
    check("reset_data", bif.outData, 128'h0);
    check("reset_ready", bif.outAesReady, 1'b0);

    // Basic path
    push_tweak({16{8'h0F}});
    bif.inAesWr   = 1'b1;
    bif.inAesData = {16{8'hFF}};
    step();
`ifdef AES_XTS_OUT_XOR_PIPE_EN
    check("basic_latency2_early", bif.outValid, 1'b0);
    step();
`endif
    check("basic_valid", bif.outValid, 1'b1);
    check("basic_data", bif.outData, {16{8'hF0}});
    step();
    check("basic_cnt", bif.outBlkCnt, 1);

    // Ordering with toggling inReady
    for (int i = 0; i < TD; i++) push_tweak(rnd128());
    check("order_full", bif.outTweakFull, 1'b1);
    issued = 0;
    n = 0;
    while ((issued < 4 || oq.size() > 0 || pq.size() > 0) && n < 60) begin
      bif.inReady = n[0];
      if (issued < 4 && m_ready()) begin
        bif.inAesWr   = 1'b1;
        bif.inAesData = rnd128();
        issued++;
      end
      step();
      n++;
    end
    check("order_cnt", bif.outBlkCnt, 5);
    bif.inReady = 1'b1;

    // Overruns
    bif.inAesWr = 1'b1;
    step();
    check("ovr_aes_err", bif.outErr, 2'b01);
    check("ovr_aes_novalid", bif.outValid, 1'b0);
    for (int i = 0; i < TD + 1; i++) push_tweak(rnd128());
    check("ovr_tweak_err", bif.outErr, 2'b11);
    bif.inErrClr = 1'b1;
    step();
    check("err_clr", bif.outErr, 2'b00);

    // Backpressure
    bif.inReady = 1'b0;
    issue_aes(rnd128());
    issue_aes(rnd128());
    step();
    check("bp_ready_low", bif.outAesReady, 1'b0);
    check("bp_tweaks_left", bif.outTweakFull, 1'b0);
    bif.inAesWr = 1'b1;
    step();
    check("bp_ovr", bif.outErr, 2'b01);
    drain();
    check("bp_ready_back", bif.outAesReady, 1'b1);

    // Flush with 2 blocks and 3 tweaks buffered
    push_tweak(rnd128());
    bif.inReady = 1'b0;
    issue_aes(rnd128());
    issue_aes(rnd128());
    push_tweak(rnd128());
    push_tweak(rnd128());
    step();
    check("pre_flush_blocks", oq.size(), 2);
    cnt_before = m_cnt;
    bif.inFlush = 1'b1;
    step();
    check("flush_valid", bif.outValid, 1'b0);
    check("flush_ready", bif.outAesReady, 1'b0);
    check("flush_cnt", bif.outBlkCnt, cnt_before);

    // Asynchronous reset mid-transfer
    bif.inReady = 1'b1;
    push_tweak(rnd128());
    issue_aes(rnd128());
    #2;
    rst = 1'b1;
    #1;
    check("rst_valid", bif.outValid, 1'b0);
    check("rst_data", bif.outData, 128'h0);
    check("rst_err", bif.outErr, 2'b00);
    check("rst_cnt", bif.outBlkCnt, 0);
    check("rst_ready", bif.outAesReady, 1'b0);
    do_reset();

    // Counter wrap
    for (int i = 0; i < 17; i++) begin
      push_tweak(rnd128());
      issue_aes(rnd128());
      drain();
    end
    check("wrap_cnt", bif.outBlkCnt, 1);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      bif.inTweakWr = ($urandom_range(0, 1) == 1);
      bif.inTweak   = rnd128();
      bif.inAesWr   = ($urandom_range(0, 1) == 1);
      bif.inAesData = rnd128();
      bif.inReady   = ($urandom_range(0, 9) < 6);
      bif.inFlush   = ($urandom_range(0, 99) < 3);
      bif.inErrClr  = ($urandom_range(0, 99) < 5);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
